// File: rtl/cp0_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiplier and restoring
// divider, one bit per cycle, with a held result and a one-cycle done pulse.
module cp0_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      fnc3,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int              CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;

    logic              sgn_a, sgn_b, div_zero, div_ovf, special, accept;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;

    // Operand decode for the launch cycle; special cases bypass iteration entirely.
    always_comb begin
        sgn_a    = opa[XLEN-1] & (fnc3 == 3'd1 || fnc3 == 3'd2 || fnc3 == 3'd4 || fnc3 == 3'd6);
        sgn_b    = opb[XLEN-1] & (fnc3 == 3'd1 || fnc3 == 3'd4 || fnc3 == 3'd6);
        mag_a    = sgn_a ? -opa : opa;
        mag_b    = sgn_b ? -opb : opb;
        div_zero = fnc3[2] && (opb == '0);
        div_ovf  = (fnc3 == 3'd4 || fnc3 == 3'd6) && (opa == MIN_INT) && (opb == '1);
        special  = div_zero | div_ovf;
        if (div_zero) special_res = fnc3[1] ? opa : '1;
        else          special_res = fnc3[1] ? '0  : MIN_INT;
        accept   = (state == IDLE) && start && !flush;
    end

    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, neg_acc;
    logic [XLEN-1:0]   neg_hi, fix_res;

    // One iteration step: multiplier in acc low half, quotient/dividend likewise.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : '0)};
        mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        diff    = rem_sh - {1'b0, b_q};
        if (!diff[XLEN]) div_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else             div_nxt = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        neg_acc = -acc_q;
        neg_hi  = -acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'd0, 3'd4, 3'd5: fix_res = neg_q ? neg_acc[XLEN-1:0] : acc_q[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_res = neg_q ? neg_acc[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
            default:          fix_res = neg_q ? neg_hi : acc_q[2*XLEN-1:XLEN];
        endcase
    end

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = special ? DONE : ITER;
            ITER: if (cnt_q == LAST) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            result <= '0;
        end else if (accept) begin
            op_q  <= fnc3;
            neg_q <= (fnc3[2] & fnc3[1]) ? sgn_a : (sgn_a ^ sgn_b);
            b_q   <= mag_b;
            acc_q <= {{XLEN{1'b0}}, mag_a};
            cnt_q <= '0;
            if (special) result <= special_res;
        end else if (!flush && state == ITER) begin
            acc_q <= op_q[2] ? div_nxt : mul_nxt;
            cnt_q <= cnt_q + CW'(1);
        end else if (!flush && state == FIX) begin
            result <= fix_res;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_cp0_muldiv_seq.sv
// Self-checking bench for cp0_muldiv_seq: directed vector table, multi-cycle
// corner sequences, and randomized ops against an arithmetic reference model.
module tb_cp0_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  fnc3;
    logic [31:0] opa, opb;
    logic        busy, done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    cp0_muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .fnc3(fnc3),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics from 64-bit products and native int division.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        logic ovf;
        ea  = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        eb  = (f == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p   = ea * eb;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0:    return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Launch one op; lat counts edges after the accepting edge until done is seen.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_cyc, output int done_cnt);
        @(negedge clk);
        fnc3 = f; opa = a; opb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; busy_cyc = 0; done_cnt = 0; res = 'x;
        for (int i = 0; i < 100; i++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin lat = i; res = result; end
            end
            if (!busy) break;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] res, prev;
        int lat, bcyc, dcnt, n;
        logic [2:0]  f;
        logic [31:0] a, b;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{3'd4, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 0};
        vecs[9]  = '{3'd6, 32'h1234_5678, 32'h0,         32'h1234_5678, 0};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0};
        vecs[12] = '{3'd5, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 0};
        vecs[13] = '{3'd2, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0004, 33};

        rst = 1'b1; start = 1'b0; flush = 1'b0; fnc3 = '0; opa = '0; opb = '0;
        #12;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, bcyc, dcnt);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d busy cycles", i), 32'(bcyc), 32'(vecs[i].lat + 1));
            check($sformatf("vec%0d done pulses", i), 32'(dcnt), 32'd1);
        end
        prev = vecs[13].exp;

        // Flush beats start while idle.
        @(negedge clk); fnc3 = 3'd0; opa = 32'd3; opb = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        check("idle flush beats start", {31'b0, busy}, 32'd0);

        // Start held high, flush in the tenth iteration cycle.
        @(negedge clk); flush = 1'b0;
        @(posedge clk); #1;
        check("flush seq busy", {31'b0, busy}, 32'd1);
        repeat (10) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        check("flush to idle", {31'b0, busy}, 32'd0);
        check("flush no done", {31'b0, done}, 32'd0);
        dcnt = 0;
        repeat (40) begin @(posedge clk); #1; if (done || busy) dcnt++; end
        check("flush quiet after", 32'(dcnt), 32'd0);
        check("flush result held", result, prev);

        // Start held through a whole op, then accepted again in the IDLE cycle after done.
        @(negedge clk); fnc3 = 3'd5; opa = 32'd100; opb = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        check("held start latency", 32'(n), 32'd33);
        check("held start result", result, 32'd14);
        fnc3 = 3'd7;
        @(posedge clk); #1;
        check("idle after done", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        check("back-to-back accepted", {31'b0, busy}, 32'd1);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        check("back-to-back latency", 32'(n), 32'd33);
        check("back-to-back result", result, 32'd2);

        // Asynchronous reset in the middle of a DIV.
        @(negedge clk); fnc3 = 3'd4; opa = 32'hFFFF_FF00; opb = 32'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        check("async rst busy", {31'b0, busy}, 32'd0);
        check("async rst done", {31'b0, done}, 32'd0);
        check("async rst result", result, 32'd0);
        @(negedge clk); rst = 1'b0;
        do_op(3'd3, 32'h0001_0000, 32'h0001_0000, res, lat, bcyc, dcnt);
        check("post-rst mulhu", res, 32'h0000_0001);
        check("post-rst latency", 32'(lat), 32'd33);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            do_op(f, a, b, res, lat, bcyc, dcnt);
            check($sformatf("rand%0d f=%0d a=%h b=%h", i, f, a, b), res, model(f, a, b));
            check($sformatf("rand%0d latency", i), 32'(lat),
                  (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 32'd0 : 32'd33);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cp0_muldiv_seq.md
# cp0_muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide coprocessor in execute stage 3. It accepts one operation per start pulse from the ID/IE-registered operands. It iterates a shift-add multiplier or a restoring divider one bit per cycle and presents a held result with a one-cycle `done` pulse. The stall unit consumes `busy`/`done` to freeze IF/ID/IE while the operation runs; a branch bubble aborts it through `flush`.

## Interface
- `XLEN`, 32: operand/result width; iteration count equals `XLEN`.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `flush`  in  1  synchronous abort from stall/branch logic.
- `fnc3`  in  3  operation select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `opa`  in  XLEN  rs1 operand (forwarded value).
- `opb`  in  XLEN  rs2 operand (forwarded value).
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle result-valid pulse; this is the stall unit's `cp0ok`.
- `result`  out  XLEN  registered result; held until the next accepted start.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE, start=1, flush=0:
  - Latch `fnc3`.
  - Latch operand magnitudes, with signedness per op: MULH/DIV/REM both signed; MULHSU `opa` signed only; others unsigned.
  - Latch result sign: `sa^sb` for product/quotient, `sa` for remainder.
  - Clear counter and accumulators.
  - Go to ITER.
- Special cases, detected at start with no ITER:
  - Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result `opa`.
  - DIV overflow (0x80000000 / 0xFFFFFFFF): DIV result 0x80000000; REM result 0.
  - Load `result` and go directly to DONE.
- ITER, multiply:
  - If the multiplier LSB is set, add the multiplicand to the upper half of the 2·XLEN accumulator.
  - Shift right by 1.
- ITER, divide (restoring):
  - Shift {rem, quotient} left by 1.
  - Trial-subtract the divisor from rem. If the result is non-negative, keep it and set the quotient LSB.
- ITER: the counter increments each cycle. After `XLEN` iterations (counter = XLEN-1 on the edge), go to FIX.
- FIX:
  - Negate the 2·XLEN product, quotient, or remainder if its latched sign is set.
  - Select into `result`: low half for MUL; high half for MULH/MULHSU/MULHU; quotient for DIV/DIVU; remainder for REM/REMU.
  - Go to DONE.
- DONE: `done`=1 for exactly this cycle; go to IDLE on the next edge unconditionally.
- `start` in any non-IDLE state is ignored; the stall unit keeps it asserted while stalled.
- `flush`:
  - From any state: return to IDLE on the next edge.
  - `done` is not asserted afterward, and `result` is unchanged.
  - flush beats start in IDLE.
- Arithmetic is modulo 2^XLEN per RV32M; the 2·XLEN accumulator never overflows.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0, accumulators 0.
- Normal op, start accepted at edge E0:
  - ITER occupies E1…E32.
  - FIX at E33 loads `result`.
  - `done`=1 in the cycle after E33 (latency 33 cycles for XLEN=32, i.e. XLEN+1).
  - IDLE after E34.
- Special case, start at E0: `result` loaded at E0, `done`=1 in the following cycle, IDLE after E1.
- `busy` rises the cycle after the accepted start and falls when IDLE is re-entered. `busy`=1 during the `done` cycle, so the stall unit stalls on `busy & ~done`.
- Back-to-back: a start seen in the IDLE cycle immediately after DONE is accepted.
- `result` is stable from the `done` cycle until the FIX or special-case load of the next op.
- Reset asserted mid-operation: immediate IDLE, all outputs to reset values, no `done`.

## Test plan
- MUL 7 × -3 (opa=0x00000007, opb=0xFFFFFFFD, fnc3=0) -> `done` exactly 33 cycles after the start edge, result 0xFFFFFFEB; `busy` high for 34 cycles.
- MULH/MULHSU/MULHU with opa=opb=0xFFFFFFFF -> results 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV by 0 with opa=0x12345678 -> 0xFFFFFFFF; REM by 0 -> 0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000. Each has `done` one cycle after start.
- Flush and back-to-back:
  - Flush at ITER cycle 10 -> IDLE next edge, no `done`, `result` keeps its previous value.
  - start held high throughout is ignored until IDLE.
  - Start issued the cycle after `done` is accepted.
- Assert `rst` asynchronously mid-DIV -> `busy`, `done`, `result` go to 0 immediately; a subsequent MULHU 0x10000 × 0x10000 returns 0x00000001.
